bus_grant_scheduler: RTL and testbench



---
 rtl/bus_pkg.sv | 23 ++
 rtl/bus_grant_scheduler_if.sv | 32 +++
 rtl/rr_pick.sv | 29 ++
 rtl/bus_grant_scheduler.sv | 120 ++++++++++++
 tb/tb_bus_grant_scheduler.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared types for the system bus: scheduler state encoding, transfer
// encodings and the index-width helper used by the scheduler and its interface.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    RELEASE = 2'd2
  } sched_state_t;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } bus_trans_t;

  // Owner index width; a single master still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_grant_scheduler_if.sv
// Request/grant bundle between the bus masters and the grant scheduler.
// Handshake: m_breq is a level held by a master until it is done with the bus;
// m_grant answers it one cycle later and stays up until txn_done, breq drop or timeout.
interface bus_grant_scheduler_if
  import bus_pkg::*;
#(
  parameter int MASTER_COUNT = 2
);
  localparam int IDX_W = idx_width(MASTER_COUNT);

  logic [MASTER_COUNT-1:0] m_breq;
  logic [MASTER_COUNT-1:0] m_lock;
  logic                    txn_done;
  logic                    err_clr;
  logic [MASTER_COUNT-1:0] m_grant;
  logic [IDX_W-1:0]        owner_idx;
  logic                    bus_busy;
  logic                    timeout_pulse;
  logic                    timeout_err;
  logic [1:0]              sched_state;

  modport master (
    output m_breq, m_lock, txn_done, err_clr,
    input  m_grant, owner_idx, bus_busy, timeout_pulse, timeout_err, sched_state
  );

  modport slave (
    input  m_breq, m_lock, txn_done, err_clr,
    output m_grant, owner_idx, bus_busy, timeout_pulse, timeout_err, sched_state
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward
// from last+1 with wrap-around.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  int cand;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    // Walking i = 1..N visits every master once, ending on last itself.
    for (int i = 1; i <= N; i++) begin
      cand = (int'(last) + i) % N;
      if (!valid && req[cand[IDX_W-1:0]]) begin
        idx   = cand[IDX_W-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_grant_scheduler.sv
// Round-robin bus grant scheduler with per-master lock and a watchdog that
// revokes a grant that goes too long without a completed transfer.
module bus_grant_scheduler
  import bus_pkg::*;
#(
  parameter int MASTER_COUNT   = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  bus_grant_scheduler_if.slave bus
);

  localparam int IDX_W = idx_width(MASTER_COUNT);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_GRANTED = GRANTED;
  localparam logic [1:0] ST_RELEASE = RELEASE;

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_MAX  = {WD_W{1'b1}};

  logic [1:0]       state;
  logic [IDX_W-1:0] owner_idx;
  logic [IDX_W-1:0] last_owner;
  logic [WD_W-1:0]  wd;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic             owner_req;
  logic             owner_lock;
  logic             timeout_hit;

  rr_pick #(
    .N     (MASTER_COUNT),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (bus.m_breq),
    .last  (last_owner),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign owner_req  = bus.m_breq[owner_idx];
  assign owner_lock = bus.m_lock[owner_idx];
  // txn_done and a dropped request both outrank the watchdog in the same cycle.
  assign timeout_hit = (state == ST_GRANTED) && !bus.txn_done && owner_req &&
                       (wd == WD_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      owner_idx     <= '0;
      last_owner    <= IDX_W'(MASTER_COUNT - 1);
      wd            <= '0;
      bus.m_grant   <= '0;
      bus.bus_busy  <= 1'b0;
      bus.timeout_pulse <= 1'b0;
    end else begin
      bus.timeout_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            owner_idx    <= pick_idx;
            bus.m_grant  <= MASTER_COUNT'(1) << pick_idx;
            bus.bus_busy <= 1'b1;
            wd           <= '0;
            state        <= ST_GRANTED;
          end
        end
        ST_GRANTED: begin
          if (bus.txn_done) begin
            if (owner_lock && owner_req) begin
              wd <= '0;
            end else begin
              bus.m_grant  <= '0;
              bus.bus_busy <= 1'b0;
              state        <= ST_RELEASE;
            end
          end else if (!owner_req) begin
            bus.m_grant  <= '0;
            bus.bus_busy <= 1'b0;
            state        <= ST_RELEASE;
          end else if (timeout_hit) begin
            bus.m_grant       <= '0;
            bus.bus_busy      <= 1'b0;
            bus.timeout_pulse <= 1'b1;
            state             <= ST_RELEASE;
          end else if (wd != WD_MAX) begin
            wd <= wd + 1'b1;
          end
        end
        ST_RELEASE: begin
          last_owner <= owner_idx;
          state      <= ST_IDLE;
        end
        default: begin
          bus.m_grant  <= '0;
          bus.bus_busy <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky error: a new timeout wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.timeout_err <= 1'b0;
    end else if (timeout_hit) begin
      bus.timeout_err <= 1'b1;
    end else if (bus.err_clr) begin
      bus.timeout_err <= 1'b0;
    end
  end

  assign bus.owner_idx   = owner_idx;
  assign bus.sched_state = state;

endmodule

// File: tb/tb_bus_grant_scheduler.sv
// Directed bench for bus_grant_scheduler: four masters, watchdog of 8 cycles.
module tb_bus_grant_scheduler;

  localparam int MC = 4;
  localparam int TO = 8;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANTED = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic clk;
  logic reset_n;
  int   tests_run;
  int   tests_failed;

  bus_grant_scheduler_if #(.MASTER_COUNT(MC)) bus ();

  bus_grant_scheduler #(
    .MASTER_COUNT   (MC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    bus.txn_done = 1'b1;
    tick();
    bus.txn_done = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_grant"}, 32'(bus.m_grant), 32'h0);
    check({tag, "_busy"},  32'(bus.bus_busy), 32'h0);
    check({tag, "_owner"}, 32'(bus.owner_idx), 32'h0);
    check({tag, "_tp"},    32'(bus.timeout_pulse), 32'h0);
    check({tag, "_terr"},  32'(bus.timeout_err), 32'h0);
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    reset_n       = 1'b0;
    bus.m_breq    = '0;
    bus.m_lock    = '0;
    bus.txn_done  = 1'b0;
    bus.err_clr   = 1'b0;

    repeat (2) tick();
    check_idle_outputs("reset");
    check("reset_state", 32'(bus.sched_state), 32'(S_IDLE));
    reset_n = 1'b1;

    // Two requesters: master 0 first, master 1 after the release turnaround.
    bus.m_breq = 4'b0011;
    tick();
    check("two_first_grant", 32'(bus.m_grant), 32'h1);
    check("two_first_busy",  32'(bus.bus_busy), 32'h1);
    pulse_done();
    check("two_release_grant", 32'(bus.m_grant), 32'h0);
    check("two_release_state", 32'(bus.sched_state), 32'(S_RELEASE));
    tick();
    check("two_turnaround_grant", 32'(bus.m_grant), 32'h0);
    check("two_turnaround_state", 32'(bus.sched_state), 32'(S_IDLE));
    tick();
    check("two_second_grant", 32'(bus.m_grant), 32'h2);
    check("two_second_owner", 32'(bus.owner_idx), 32'h1);
    bus.m_breq = '0;
    pulse_done();
    tick();

    // Fresh reset, then all four requesting: order 0,1,2,3,0.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.m_breq = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("rr_grant_%0d", k), 32'(bus.m_grant), 32'(1 << (k % 4)));
      check($sformatf("rr_owner_%0d", k), 32'(bus.owner_idx), 32'(k % 4));
      check($sformatf("rr_onehot_%0d", k), 32'($countones(bus.m_grant)), 32'd1);
      pulse_done();
      check($sformatf("rr_drop_%0d", k), 32'(bus.m_grant), 32'h0);
      tick();
    end

    // Lock: master 1 keeps the bus across three transfers while master 0 waits.
    bus.m_breq = 4'b0011;
    bus.m_lock = 4'b0010;
    tick();
    check("lock_grant", 32'(bus.m_grant), 32'h2);
    for (int k = 0; k < 3; k++) begin
      pulse_done();
      check($sformatf("lock_hold_a_%0d", k), 32'(bus.m_grant), 32'h2);
      tick();
      check($sformatf("lock_hold_b_%0d", k), 32'(bus.m_grant), 32'h2);
    end
    bus.m_lock = '0;
    pulse_done();
    check("unlock_release", 32'(bus.m_grant), 32'h0);
    tick();
    tick();
    check("unlock_next_grant", 32'(bus.m_grant), 32'h1);
    check("unlock_next_owner", 32'(bus.owner_idx), 32'h0);

    // Watchdog: master 0 holds the grant with no txn_done.
    for (int k = 1; k < TO; k++) begin
      tick();
      check($sformatf("wd_hold_%0d", k), 32'(bus.m_grant), 32'h1);
      check($sformatf("wd_tp_low_%0d", k), 32'(bus.timeout_pulse), 32'h0);
    end
    tick();
    check("wd_revoke_grant", 32'(bus.m_grant), 32'h0);
    check("wd_revoke_busy",  32'(bus.bus_busy), 32'h0);
    check("wd_pulse",        32'(bus.timeout_pulse), 32'h1);
    check("wd_err_set",      32'(bus.timeout_err), 32'h1);
    bus.m_breq = 4'b0001;
    tick();
    check("wd_pulse_once", 32'(bus.timeout_pulse), 32'h0);
    check("wd_err_sticky", 32'(bus.timeout_err), 32'h1);
    tick();
    check("wd_regrant", 32'(bus.m_grant), 32'h1);
    check("wd_err_still", 32'(bus.timeout_err), 32'h1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("err_clr", 32'(bus.timeout_err), 32'h0);

    // Abandoned request: release next cycle without a timeout.
    bus.m_breq = '0;
    tick();
    check("abandon_grant", 32'(bus.m_grant), 32'h0);
    check("abandon_state", 32'(bus.sched_state), 32'(S_RELEASE));
    check("abandon_no_tp", 32'(bus.timeout_pulse), 32'h0);
    tick();

    // Reset mid-grant drops everything at once; master 0 wins afterwards.
    bus.m_breq = 4'b0100;
    tick();
    check("pre_reset_grant", 32'(bus.m_grant), 32'h4);
    check("pre_reset_state", 32'(bus.sched_state), 32'(S_GRANTED));
    reset_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    bus.m_breq = 4'b0101;
    tick();
    reset_n = 1'b1;
    tick();
    check("post_reset_grant", 32'(bus.m_grant), 32'h1);
    check("post_reset_owner", 32'(bus.owner_idx), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
